// File: rtl/range_counter.sv
// Bounded up/down counter over [MIN, MAX] with programmable step and wrap/saturate/bounce boundary modes.
// Optional prescaler is built only when RANGE_COUNTER_PRESCALE_EN is defined.
module range_counter #(
    parameter int WIDTH      = 8,
    parameter int MIN        = 10,
    parameter int MAX        = 100,
    parameter int STEP_WIDTH = 4,
    parameter int PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  set,
    input  logic [WIDTH-1:0]      din,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  up_down,
    input  logic [1:0]            mode,
    output logic [WIDTH-1:0]      count,
    output logic                  dir,
    output logic                  at_min,
    output logic                  at_max,
    output logic                  finish,
    output logic                  wrapped
);

    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam bit PRESCALE_VALID = (PRESCALE >= 1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             finish_reg, finish_next;
    logic             wrapped_reg, wrapped_next;

    logic             advance;
    logic             wrap_mode, bounce_mode, eff_dir;
    logic [WIDTH:0]   count_x, step_x, sum_x, floor_x, din_x;
    logic [WIDTH-1:0] diff_w, din_clamped;
    logic             up_over, up_hit, dn_over, dn_hit;

    assign wrap_mode   = (mode == 2'd0);
    assign bounce_mode = (mode == 2'd2);
    // In bounce mode the stored direction drives travel; otherwise the request does.
    assign eff_dir     = bounce_mode ? dir_reg : up_down;

    // Boundary arithmetic is done one bit wider so overflow/underflow stay visible.
    assign count_x = {1'b0, count_reg};
    assign step_x  = {{(WIDTH+1-STEP_WIDTH){1'b0}}, step};
    assign sum_x   = count_x + step_x;
    assign floor_x = MIN_X + step_x;
    assign diff_w  = count_reg - step_x[WIDTH-1:0];

    assign up_over = (sum_x > MAX_X);
    assign up_hit  = (sum_x == MAX_X);
    assign dn_over = (count_x < floor_x);
    assign dn_hit  = (count_x == floor_x);

    assign din_x       = {1'b0, din};
    assign din_clamped = (din_x < MIN_X) ? MIN_W :
                         (din_x > MAX_X) ? MAX_W : din;

`ifdef RANGE_COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic          presc_tick;

    assign presc_tick = (presc_reg == PRESCALE_LAST);
    assign advance    = en && presc_tick && PRESCALE_VALID;

    always_comb begin
        presc_next = presc_reg;
        if (set) begin
            presc_next = '0;
        end else if (en) begin
            presc_next = presc_tick ? '0 : presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end
`else
    assign advance = en && PRESCALE_VALID;
`endif

    always_comb begin
        count_next   = count_reg;
        dir_next     = bounce_mode ? dir_reg : up_down;
        finish_next  = 1'b0;
        wrapped_next = 1'b0;

        if (set) begin
            count_next = din_clamped;
            dir_next   = up_down;
        end else if (advance && (step != '0)) begin
            if (eff_dir) begin
                if (up_hit) begin
                    count_next  = MAX_W;
                    finish_next = 1'b1;
                    if (bounce_mode) begin
                        dir_next = 1'b0;
                    end
                end else if (up_over) begin
                    if (wrap_mode) begin
                        count_next   = MIN_W;
                        wrapped_next = 1'b1;
                    end else if (bounce_mode) begin
                        count_next  = MAX_W;
                        finish_next = 1'b1;
                        dir_next    = 1'b0;
                    end else begin
                        count_next  = MAX_W;
                        finish_next = (count_reg != MAX_W);
                    end
                end else begin
                    count_next = sum_x[WIDTH-1:0];
                end
            end else begin
                if (dn_hit) begin
                    count_next  = MIN_W;
                    finish_next = 1'b1;
                    if (bounce_mode) begin
                        dir_next = 1'b1;
                    end
                end else if (dn_over) begin
                    if (wrap_mode) begin
                        count_next   = MAX_W;
                        wrapped_next = 1'b1;
                    end else if (bounce_mode) begin
                        count_next  = MIN_W;
                        finish_next = 1'b1;
                        dir_next    = 1'b1;
                    end else begin
                        count_next  = MIN_W;
                        finish_next = (count_reg != MIN_W);
                    end
                end else begin
                    count_next = diff_w;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= MIN_W;
            dir_reg     <= 1'b1;
            finish_reg  <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            dir_reg     <= dir_next;
            finish_reg  <= finish_next;
            wrapped_reg <= wrapped_next;
        end
    end

    assign count   = count_reg;
    assign dir     = dir_reg;
    assign finish  = finish_reg;
    assign wrapped = wrapped_reg;
    assign at_min  = (count_reg == MIN_W);
    assign at_max  = (count_reg == MAX_W);

endmodule

// File: tb/tb_range_counter.sv
// Directed self-checking bench for range_counter (WIDTH=8, MIN=10, MAX=100, STEP_WIDTH=4).
// The prescaler sequence runs instead of the main sequence when RANGE_COUNTER_PRESCALE_EN is defined.
module tb_range_counter;

    logic       clk = 1'b0;
    logic       rst, en, set, up_down;
    logic [7:0] din;
    logic [3:0] step;
    logic [1:0] mode;
    logic [7:0] count;
    logic       dir, at_min, at_max, finish, wrapped;

    int compared   = 0;
    int mismatched = 0;

    range_counter #(
        .WIDTH(8), .MIN(10), .MAX(100), .STEP_WIDTH(4), .PRESCALE(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .set(set), .din(din), .step(step),
        .up_down(up_down), .mode(mode), .count(count), .dir(dir),
        .at_min(at_min), .at_max(at_max), .finish(finish), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-18s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input logic [7:0] c, input logic f, input logic w);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".finish"}, 32'(finish), 32'(f));
        check({tag, ".wrapped"}, 32'(wrapped), 32'(w));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; set = 1'b0; up_down = 1'b1;
        din = 8'd0; step = 4'd0; mode = 2'd0;

        // reset held three cycles with en high
        tick(); tick(); tick();
        check_state("reset", 8'd10, 1'b0, 1'b0);
        check("reset.at_min", 32'(at_min), 32'd1);
        check("reset.at_max", 32'(at_max), 32'd0);
        check("reset.dir", 32'(dir), 32'd1);
        rst = 1'b0; en = 1'b0;

`ifndef RANGE_COUNTER_PRESCALE_EN
        // wrap up
        mode = 2'd0; up_down = 1'b1; step = 4'd3; set = 1'b1; din = 8'd97;
        tick();
        check_state("wrap.load", 8'd97, 1'b0, 1'b0);
        set = 1'b0; en = 1'b1;
        tick();
        check_state("wrap.hit", 8'd100, 1'b1, 1'b0);
        check("wrap.at_max", 32'(at_max), 32'd1);
        tick();
        check_state("wrap.over", 8'd10, 1'b0, 1'b1);
        tick();
        check_state("wrap.after", 8'd13, 1'b0, 1'b0);

        // saturate down
        en = 1'b0; mode = 2'd1; up_down = 1'b0; step = 4'd4; set = 1'b1; din = 8'd15;
        tick();
        check_state("sat.load", 8'd15, 1'b0, 1'b0);
        check("sat.dir", 32'(dir), 32'd0);
        set = 1'b0; en = 1'b1;
        tick();
        check_state("sat.step", 8'd11, 1'b0, 1'b0);
        tick();
        check_state("sat.bound", 8'd10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state("sat.hold", 8'd10, 1'b0, 1'b0);
        end

        // bounce
        en = 1'b0; mode = 2'd2; step = 4'd5; up_down = 1'b1; set = 1'b1; din = 8'd95;
        tick();
        check_state("bnc.load", 8'd95, 1'b0, 1'b0);
        check("bnc.load.dir", 32'(dir), 32'd1);
        set = 1'b0; en = 1'b1; up_down = 1'b0;
        tick();
        check_state("bnc.hit", 8'd100, 1'b1, 1'b0);
        check("bnc.hit.dir", 32'(dir), 32'd0);
        tick();
        check_state("bnc.down1", 8'd95, 1'b0, 1'b0);
        up_down = 1'b1;
        tick();
        check_state("bnc.down2", 8'd90, 1'b0, 1'b0);
        check("bnc.ignore.dir", 32'(dir), 32'd0);
        tick();
        check_state("bnc.down3", 8'd85, 1'b0, 1'b0);

        // set clamping and priority
        en = 1'b0; mode = 2'd0; up_down = 1'b1; step = 4'd3;
        set = 1'b1; din = 8'd5;
        tick();
        check_state("clamp.low", 8'd10, 1'b0, 1'b0);
        din = 8'd200;
        tick();
        check_state("clamp.high", 8'd100, 1'b0, 1'b0);
        en = 1'b1; din = 8'd99;
        tick();
        check_state("set_en.99", 8'd99, 1'b0, 1'b0);
        din = 8'd100;
        tick();
        check_state("set_en.100", 8'd100, 1'b0, 1'b0);
        rst = 1'b1; din = 8'd50;
        tick();
        check_state("rst_set", 8'd10, 1'b0, 1'b0);
        rst = 1'b0; set = 1'b0;

        // zero step holds, downward wrap, enable freeze
        en = 1'b1; step = 4'd0; up_down = 1'b1;
        tick();
        check_state("step0", 8'd10, 1'b0, 1'b0);
        step = 4'd3; up_down = 1'b0;
        tick();
        check_state("wrapdn.over", 8'd100, 1'b0, 1'b1);
        tick();
        check_state("wrapdn.after", 8'd97, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        check_state("freeze", 8'd97, 1'b0, 1'b0);
`else
        // prescaler: one advance per 4 enabled cycles
        mode = 2'd1; up_down = 1'b1; step = 4'd1; set = 1'b1; din = 8'd20;
        tick();
        check_state("pre.load", 8'd20, 1'b0, 1'b0);
        set = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("pre.wait", 8'd20, 1'b0, 1'b0);
        end
        tick();
        check_state("pre.adv1", 8'd21, 1'b0, 1'b0);
        tick(); tick();
        check_state("pre.phase2", 8'd21, 1'b0, 1'b0);
        en = 1'b0;
        tick(); tick();
        check_state("pre.frozen", 8'd21, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        check_state("pre.phase3", 8'd21, 1'b0, 1'b0);
        tick();
        check_state("pre.adv2", 8'd22, 1'b0, 1'b0);
        tick(); tick();
        set = 1'b1; din = 8'd30;
        tick();
        check_state("pre.set", 8'd30, 1'b0, 1'b0);
        set = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("pre.rewait", 8'd30, 1'b0, 1'b0);
        end
        tick();
        check_state("pre.adv3", 8'd31, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
